matrix_io_ctrl: RTL and testbench
=================================

Name: matrix_io_ctrl

Overview:
- Host-side front end for the 5x5 InverseMatrix engine: the feeder/collector at the other end of its `ram1`/`start`/`write` interface.
- Accepts the 25 words of matrix A over a valid/ready stream, pulses `start`, and serves the engine's element reads on `ram1`.
- Captures the engine's 25 result words from `write`, then streams the inverse back to the host in row-major order.

Parameters:
- N, 5, matrix dimension (N*N elements, row-major).
- DW, 32, data word width (opaque to this block).
- AW, 5, element address width; must satisfy 2^AW >= N*N.
- TIMEOUT, 4096, RUN cycles allowed before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  host element of A, row-major.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data.
- start  out  1  one-cycle start pulse to the inverse engine.
- rd_addr  in  AW  engine read address into A.
- ram1  out  DW  read data for rd_addr, one-cycle latency.
- write  in  DW  engine result word.
- wr_addr  in  AW  result element index.
- wr_en  in  1  write strobe.
- out_data  out  DW  result element to host.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts out_data.
- out_last  out  1  marks element N*N-1.
- busy  out  1  high in START/RUN/DRAIN.
- err  out  2  sticky flags: bit0 bad wr_addr, bit1 timeout; cleared on entry to START.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; load_cnt=0, out_cnt=0, timer=0.
  - Result-valid bitmap = 0; err=0.
  - Outputs: in_ready=1, start=0, ram1=0, out_valid=0, out_last=0, busy=0.
  - Memory contents undefined.
- Reset mid-operation aborts immediately; no further start pulse and no out_valid until a new full load.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes memA[load_cnt] and increments load_cnt.
  - The handshake with load_cnt==N*N-1 moves to START and clears load_cnt.
- START:
  - start=1 for exactly one cycle; in_ready=0; busy=1.
  - Clears bitmap, err and timer; next state RUN.
- RUN:
  - Every cycle, ram1 <= memA[rd_addr] when rd_addr<N*N, else 0 (registered, 1-cycle latency).
  - wr_en with wr_addr<N*N: memR[wr_addr]<=write and bitmap bit is set; a duplicate write overwrites and counts once.
  - wr_en with wr_addr>=N*N: write ignored, err[0] set.
  - Cycle after the bitmap is all-ones: go to DRAIN.
  - timer increments each RUN cycle; when it reaches TIMEOUT-1 with the bitmap incomplete, set err[1] and go to DRAIN. Unwritten elements read out as 0 (memR cleared lazily via the bitmap mask on read).
  - in_valid is ignored outside LOAD (in_ready=0).
- DRAIN:
  - out_valid=1; out_data=memR[out_cnt] masked by bitmap; out_last=(out_cnt==N*N-1).
  - out_valid&out_ready advances out_cnt.
  - Handshake on out_last: out_cnt=0, state=LOAD, busy=0.
  - out_data is held stable while out_valid&!out_ready.
  - wr_en in DRAIN or LOAD is ignored and raises no error.
- Simultaneous events:
  - The final wr_en and a timeout in the same cycle: the write wins, no timeout flag.
  - rd_addr is served in all states; ram1 keeps updating from memA.
- State encoding: LOAD=0, START=1, RUN=2, DRAIN=3.

Test Plan:
- Load A=identity (1.0 as 32'h0001_0000 on diagonal) with in_valid held 1 -> in_ready drops after 25 handshakes; start high exactly 1 cycle; busy=1.
- Engine model reads rd_addr 0..24 -> ram1 matches each loaded word one cycle later; rd_addr=30 -> ram1=0.
- Model writes 25 results out of order, address 7 twice (values 0xA then 0xB) -> DRAIN entered once all 25 are captured; element 7 out = 0xB; out_last on the 25th beat only; err=0.
- Host out_ready toggles 1/0 every cycle during DRAIN -> out_data stable while stalled; 25 beats total; returns to LOAD with in_ready=1.
- Model writes only 24 elements, TIMEOUT=64 -> err=2'b10 at cycle 64 of RUN; missing element read out as 0.
- wr_en with wr_addr=27 in RUN -> err[0]=1, no memory change. Separately, rst_n pulsed low mid-RUN -> all outputs at reset values asynchronously; a following load restarts cleanly.

Source files
------------

// File: rtl/matrix_io_ctrl.sv
// matrix_io_ctrl: host-side front end for the NxN inverse-matrix engine.
//   Loads the N*N words of A over a valid/ready stream, pulses start, serves
//   the engine's registered reads of A on ram1, captures the engine's result
//   words, then streams the result back to the host in row-major order.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      host input stream (elements of A)
//   start                          one-cycle start pulse to the engine
//   rd_addr -> ram1                engine read port into A, 1-cycle latency
//   write/wr_addr/wr_en            engine result write port
//   out_data/out_valid/out_ready   host output stream, out_last on element N*N-1
//   busy                           high in START/RUN/DRAIN
//   err                            sticky: bit0 bad wr_addr, bit1 timeout
module matrix_io_ctrl #(
  parameter int unsigned N       = 5,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          start,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] ram1,
  input  logic [DW-1:0] write,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_en,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic [1:0]    err
);

  localparam int unsigned NumEl = N * N;
  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned TW    = $clog2(TIMEOUT) + 1;
  localparam logic [AW-1:0] LastIdx   = AW'(NumEl - 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   load_cnt_q, load_cnt_d;
  logic [AW-1:0]   out_cnt_q, out_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [Depth-1:0] bitmap_q, bitmap_d, bitmap_set;
  logic [1:0]      err_q, err_d;

  logic [DW-1:0] mem_a [Depth];
  logic [DW-1:0] mem_r [Depth];

  logic wr_ok, wr_bad, full_q, full_d;

  assign wr_ok  = (state_q == StRun) && wr_en && (wr_addr <= LastIdx);
  assign wr_bad = (state_q == StRun) && wr_en && (wr_addr > LastIdx);

  always_comb begin
    bitmap_set = bitmap_q;
    if (wr_ok) bitmap_set[wr_addr] = 1'b1;
  end

  assign full_q = &bitmap_q[NumEl-1:0];
  // Completion including this cycle's write: a final write beats a timeout.
  assign full_d = &bitmap_set[NumEl-1:0];

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    out_cnt_d  = out_cnt_q;
    timer_d    = timer_q;
    bitmap_d   = bitmap_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    start      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (load_cnt_q == LastIdx) begin
            load_cnt_d = '0;
            state_d    = StStart;
            bitmap_d   = '0;
            err_d      = '0;
            timer_d    = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        start   = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        bitmap_d = bitmap_set;
        timer_d  = timer_q + 1'b1;
        if (wr_bad) err_d[0] = 1'b1;
        if (full_q) begin
          state_d = StDrain;
        end else if (timer_q == TimerLast && !full_d) begin
          err_d[1] = 1'b1;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_cnt_q == LastIdx) begin
            out_cnt_d = '0;
            state_d   = StLoad;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign out_last = (state_q == StDrain) && (out_cnt_q == LastIdx);
  // Unwritten results read as zero, so memR never needs an explicit clear.
  assign out_data = bitmap_q[out_cnt_q] ? mem_r[out_cnt_q] : '0;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      out_cnt_q  <= '0;
      timer_q    <= '0;
      bitmap_q   <= '0;
      err_q      <= '0;
      ram1       <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      out_cnt_q  <= out_cnt_d;
      timer_q    <= timer_d;
      bitmap_q   <= bitmap_d;
      err_q      <= err_d;
      ram1       <= (rd_addr <= LastIdx) ? mem_a[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem_a[load_cnt_q] <= in_data;
    if (wr_ok) mem_r[wr_addr] <= write;
  end

endmodule

// File: tb/tb_matrix_io_ctrl.sv
`timescale 1ns/1ps
module tb_matrix_io_ctrl;

  localparam int N = 5, DW = 32, AW = 5, TIMEOUT = 64, NE = N * N;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, start, out_valid, out_last, busy;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] ram1, out_data;
  logic [DW-1:0] write = '0;
  logic          wr_en = 1'b0, out_ready = 1'b0;
  logic [1:0]    err;

  matrix_io_ctrl #(.N(N), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .rd_addr(rd_addr), .ram1(ram1),
    .write(write), .wr_addr(wr_addr), .wr_en(wr_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 load, 1 start, 2 run, 3 drain
  int          m_phase, m_load, m_out, m_runcyc;
  logic [31:0] m_a [NE];
  bit          m_ak [NE];
  logic [31:0] m_r [NE];
  bit          m_w [NE];
  logic [1:0]  m_err;
  logic [31:0] m_ram1;
  bit          m_ram1k;

  function automatic int n_written();
    int c = 0;
    for (int i = 0; i < NE; i++) c += int'(m_w[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_load = 0; m_out = 0; m_runcyc = 0; m_err = 2'b00;
    m_ram1 = 0; m_ram1k = 1'b1;
    for (int i = 0; i < NE; i++) begin m_w[i] = 1'b0; m_ak[i] = 1'b0; end
  endtask

  task automatic model_step();
    bit was_full;
    if (int'(rd_addr) < NE) begin
      m_ram1 = m_a[rd_addr]; m_ram1k = m_ak[rd_addr];
    end else begin
      m_ram1 = 0; m_ram1k = 1'b1;
    end
    case (m_phase)
      0: if (in_valid) begin
        m_a[m_load] = in_data; m_ak[m_load] = 1'b1;
        if (m_load == NE - 1) begin
          m_load = 0; m_phase = 1; m_err = 2'b00; m_runcyc = 0;
          for (int i = 0; i < NE; i++) m_w[i] = 1'b0;
        end else m_load++;
      end
      1: m_phase = 2;
      2: begin
        was_full = (n_written() == NE);
        if (wr_en) begin
          if (int'(wr_addr) < NE) begin m_r[wr_addr] = write; m_w[wr_addr] = 1'b1; end
          else m_err[0] = 1'b1;
        end
        m_runcyc++;
        if (was_full) m_phase = 3;
        else if (m_runcyc == TIMEOUT && n_written() != NE) begin
          m_err[1] = 1'b1; m_phase = 3;
        end
      end
      3: if (out_ready) begin
        if (m_out == NE - 1) begin m_out = 0; m_phase = 0; end
        else m_out++;
      end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic        pv, pr;
    logic [31:0] pd;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      check1("in_ready", in_ready, m_phase == 0);
      check1("start", start, m_phase == 1);
      check1("busy", busy, m_phase != 0);
      check1("out_valid", out_valid, m_phase == 3);
      check1("out_last", out_last, (m_phase == 3) && (m_out == NE - 1));
      check("err", {30'b0, err}, {30'b0, m_err});
      if (m_ram1k) check("ram1", ram1, m_ram1);
      if (m_phase == 3) check("out_data", out_data, m_w[m_out] ? m_r[m_out] : 32'h0);
      if (pv && !pr && out_valid) check("out_hold", out_data, pd);
      pv = out_valid && rst_n; pr = out_ready; pd = out_data;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { int addr; logic [31:0] val; } wr_t;
  logic [31:0] a_vals [NE];
  logic [31:0] r_exp [NE];
  wr_t         wl [$];
  logic [31:0] beat_q [$];
  int          last_pos;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_matrix(input bit gaps);
    int i = 0, g = 0;
    bit hs;
    while (i < NE && g < 2000) begin
      in_data  = a_vals[i];
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      hs = in_valid && in_ready;
      tick(); g++;
      if (hs) i++;
    end
    check("load_count", i, NE);
  endtask

  task automatic make_list(input int missing, input bit dup7, input bit bad27);
    int perm [NE];
    int t;
    logic [31:0] v;
    for (int k = 0; k < NE; k++) begin perm[k] = k; r_exp[k] = 32'h0; end
    for (int k = NE - 1; k > 0; k--) begin
      int j = int'($urandom_range(0, k));
      t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
    if (dup7 && perm[NE-1] == 7) begin perm[NE-1] = perm[0]; perm[0] = 7; end
    wl.delete();
    for (int k = 0; k < NE; k++) begin
      if (perm[k] != missing) begin
        v = (dup7 && perm[k] == 7) ? 32'hA : $urandom;
        wl.push_back('{perm[k], v}); r_exp[perm[k]] = v;
      end
      if (dup7 && k == NE - 2) begin wl.push_back('{7, 32'hB}); r_exp[7] = 32'hB; end
    end
    if (bad27) wl.push_front('{27, 32'hDEAD_BEEF});
  endtask

  task automatic run_engine(output int runcyc);
    int g = 0;
    while (!start && g < 50) begin tick(); g++; end
    check1("start_seen", start, 1'b1);
    check1("busy_start", busy, 1'b1);
    check1("in_ready_start", in_ready, 1'b0);
    tick();
    check1("start_one_cycle", start, 1'b0);
    runcyc = 0;
    while (!out_valid && runcyc < TIMEOUT + 20) begin
      rd_addr = (runcyc < NE) ? AW'(runcyc) : (runcyc == NE) ? AW'(30) : AW'($urandom_range(0, 31));
      if (runcyc < wl.size()) begin
        wr_en = 1'b1; wr_addr = AW'(wl[runcyc].addr); write = wl[runcyc].val;
      end else wr_en = 1'b0;
      if (runcyc == 2) in_valid = 1'b0;
      tick(); runcyc++;
      if (runcyc - 1 < NE) check("ram1_rd", ram1, a_vals[runcyc-1]);
      else if (runcyc - 1 == NE) check("ram1_oob", ram1, 32'h0);
    end
    wr_en = 1'b0; in_valid = 1'b0;
    check1("drain_reached", out_valid, 1'b1);
  endtask

  task automatic drain(input int mode);
    int g = 0;
    bit hs, done = 1'b0;
    beat_q.delete(); last_pos = -1;
    while (!done && g < 500) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 2) == 0) : 1'($urandom_range(0, 1));
      hs = out_valid && out_ready;
      if (hs) begin
        beat_q.push_back(out_data);
        if (out_last) begin last_pos = beat_q.size(); done = 1'b1; end
      end
      tick(); g++;
    end
    out_ready = 1'b0;
    check("beats", beat_q.size(), NE);
    check("last_pos", last_pos, NE);
    check1("back_to_load", in_ready, 1'b1);
    check1("busy_idle", busy, 1'b0);
    for (int k = 0; k < NE && k < beat_q.size(); k++) check("beat_val", beat_q[k], r_exp[k]);
  endtask

  task automatic rand_a();
    for (int k = 0; k < NE; k++) a_vals[k] = $urandom;
  endtask

  task automatic reset_literals(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    check1({tag, "_start"}, start, 1'b0);
    check({tag, "_ram1"}, ram1, 32'h0);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check1({tag, "_out_last"}, out_last, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, {30'b0, err}, 32'h0);
  endtask

  initial begin
    int rc, miss, cnt;
    #22 reset_literals("rst");
    #5 rst_n = 1'b1;
    tick();
    reset_literals("post_rst");

    // Identity matrix, in_valid held high, duplicate write to element 7.
    for (int k = 0; k < NE; k++) a_vals[k] = (k % (N + 1) == 0) ? 32'h0001_0000 : 32'h0;
    load_matrix(1'b0);
    make_list(-1, 1'b1, 1'b0);
    run_engine(rc);
    check("run_cycles_full", rc, wl.size() + 1);
    check("err_full", {30'b0, err}, 32'h0);
    drain(1);
    check("elem7", beat_q[7], 32'hB);

    // Random matrix, gappy load, random host back-pressure.
    rand_a(); load_matrix(1'b1);
    make_list(-1, 1'b0, 1'b0);
    run_engine(rc);
    check("run_cycles_rand", rc, wl.size() + 1);
    drain(2);

    // Timeout: one element never written.
    miss = int'($urandom_range(0, NE - 1));
    rand_a(); load_matrix(1'b0);
    make_list(miss, 1'b0, 1'b0);
    run_engine(rc);
    check("run_cycles_timeout", rc, TIMEOUT);
    check("err_timeout", {30'b0, err}, 32'h2);
    drain(0);
    check("missing_zero", beat_q[miss], 32'h0);
    check("err_sticky", {30'b0, err}, 32'h2);

    // Out-of-range write address.
    rand_a(); load_matrix(1'b1);
    make_list(-1, 1'b0, 1'b1);
    run_engine(rc);
    check("err_badaddr", {30'b0, err}, 32'h1);
    drain(2);

    // Asynchronous reset in the middle of RUN.
    rand_a(); load_matrix(1'b0);
    make_list(-1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_addr = AW'(wl[k].addr); write = wl[k].val; tick();
    end
    #2 rst_n = 1'b0;
    #1 reset_literals("async_rst");
    wr_en = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin tick(); cnt += int'(start) + int'(out_valid); end
    check("idle_after_rst", cnt, 0);
    rand_a(); load_matrix(1'b0);
    make_list(-1, 1'b0, 1'b0);
    run_engine(rc);
    check("err_after_rst", {30'b0, err}, 32'h0);
    drain(2);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
